// File: rtl/hazard_match_tracker_if.sv
// Hazard-tracker bundle: D-stage fields and hazard-unit feedback in, match/writeback
// controls and event counters out.
interface hazard_match_tracker_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              ValidD;
  logic [REG_AW-1:0] RA1D, RA2D, RA3D, RA4D, WA3D;
  logic [1:0]        RegWriteD;
  logic              MemtoRegD, PCSrcD, CondExE, StallD, FlushE;

  logic              Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W;
  logic              Match_3E_M, Match_3E_W, Match_4E_M, Match_4E_W;
  logic              Match_12D_E;
  logic [1:0]        RegWriteM, RegWriteW;
  logic              MemtoRegE, PCWrPendingF, PCSrcW;
  logic [CNT_W-1:0]  StallCnt, FlushCnt;

  modport master (
    output ValidD, RA1D, RA2D, RA3D, RA4D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
           CondExE, StallD, FlushE,
    input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
           Match_3E_M, Match_3E_W, Match_4E_M, Match_4E_W,
           Match_12D_E, RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW,
           StallCnt, FlushCnt
  );

  modport slave (
    input  ValidD, RA1D, RA2D, RA3D, RA4D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
           CondExE, StallD, FlushE,
    output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
           Match_3E_M, Match_3E_W, Match_4E_M, Match_4E_W,
           Match_12D_E, RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW,
           StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_match_tracker.sv
// Carries register addresses and writeback controls D->E->M->W and derives the
// hazard-unit match/pending inputs, plus saturating stall/flush event counters.

// One source operand in E compared against the M and W destinations.
module hazard_src_cmp #(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] ra_e,
  input  logic [REG_AW-1:0] wa3_m,
  input  logic [REG_AW-1:0] wa3_w,
  input  logic              v_e,
  input  logic              v_m,
  input  logic              v_w,
  output logic              hit_m,
  output logic              hit_w
);
  assign hit_m = v_e & v_m & (ra_e == wa3_m);
  assign hit_w = v_e & v_w & (ra_e == wa3_w);
endmodule

module hazard_match_tracker #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_match_tracker_if.slave hif
);
  localparam int STAGES = 3;
  localparam int NSRC   = 4;
  localparam int SE     = 1;
  localparam int SM     = 2;
  localparam int SW     = 3;

  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1]             pcs_pipe;
  logic [STAGES:1][REG_AW-1:0] wa3_pipe;
  logic [STAGES:1][1:0]        rw_pipe;
  logic [NSRC-1:0][REG_AW-1:0] ra_d, ra_e;
  logic                        mtr_e;
  logic [NSRC-1:0]             hit_m, hit_w;
  logic [CNT_W-1:0]            stall_cnt, flush_cnt;

  assign ra_d = {hif.RA4D, hif.RA3D, hif.RA2D, hif.RA1D};

  // Flush only kills the controls; E addresses are left stale since V gates every match.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      pcs_pipe <= '0;
      wa3_pipe <= '0;
      rw_pipe  <= '0;
      ra_e     <= '0;
      mtr_e    <= 1'b0;
    end else begin
      if (hif.FlushE) begin
        vld_pipe[SE] <= 1'b0;
        rw_pipe[SE]  <= 2'b00;
        pcs_pipe[SE] <= 1'b0;
        mtr_e        <= 1'b0;
      end else begin
        vld_pipe[SE] <= hif.ValidD;
        ra_e         <= ra_d;
        wa3_pipe[SE] <= hif.WA3D;
        rw_pipe[SE]  <= hif.RegWriteD & {2{hif.ValidD}};
        pcs_pipe[SE] <= hif.PCSrcD & hif.ValidD;
        mtr_e        <= hif.MemtoRegD & hif.ValidD;
      end
      // Condition failure squashes the side effects but keeps the slot valid.
      vld_pipe[SM] <= vld_pipe[SE];
      wa3_pipe[SM] <= wa3_pipe[SE];
      rw_pipe[SM]  <= rw_pipe[SE] & {2{hif.CondExE}};
      pcs_pipe[SM] <= pcs_pipe[SE] & hif.CondExE;
      vld_pipe[SW] <= vld_pipe[SM];
      wa3_pipe[SW] <= wa3_pipe[SM];
      rw_pipe[SW]  <= rw_pipe[SM];
      pcs_pipe[SW] <= pcs_pipe[SM];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hif.StallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (hif.FlushE && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  for (genvar n = 0; n < NSRC; n++) begin : g_src
    hazard_src_cmp #(.REG_AW(REG_AW)) u_cmp (
      .ra_e  (ra_e[n]),
      .wa3_m (wa3_pipe[SM]),
      .wa3_w (wa3_pipe[SW]),
      .v_e   (vld_pipe[SE]),
      .v_m   (vld_pipe[SM]),
      .v_w   (vld_pipe[SW]),
      .hit_m (hit_m[n]),
      .hit_w (hit_w[n])
    );
  end

  assign hif.Match_1E_M = hit_m[0];
  assign hif.Match_1E_W = hit_w[0];
  assign hif.Match_2E_M = hit_m[1];
  assign hif.Match_2E_W = hit_w[1];
  assign hif.Match_3E_M = hit_m[2];
  assign hif.Match_3E_W = hit_w[2];
  assign hif.Match_4E_M = hit_m[3];
  assign hif.Match_4E_W = hit_w[3];

  assign hif.Match_12D_E  = hif.ValidD & vld_pipe[SE] & rw_pipe[SE][0] &
                            ((hif.RA1D == wa3_pipe[SE]) | (hif.RA2D == wa3_pipe[SE]));
  assign hif.PCWrPendingF = (hif.PCSrcD & hif.ValidD) | pcs_pipe[SE] | pcs_pipe[SM];
  assign hif.RegWriteM    = rw_pipe[SM];
  assign hif.RegWriteW    = rw_pipe[SW];
  assign hif.MemtoRegE    = mtr_e;
  assign hif.PCSrcW       = pcs_pipe[SW];
  assign hif.StallCnt     = stall_cnt;
  assign hif.FlushCnt     = flush_cnt;
endmodule

// File: tb/tb_hazard_match_tracker.sv
// Directed bench: reset, dependent pair, load-use, condition fail, PC write, counter saturation.
module tb_hazard_match_tracker;
  logic clk, reset;
  int   nt, nf;

  hazard_match_tracker_if #(.REG_AW(4), .CNT_W(3)) hif ();

  hazard_match_tracker #(.REG_AW(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nt++;
    assert (got === exp) else begin
      nf++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_d(input logic v, input logic [3:0] ra1, input logic [3:0] ra2,
                         input logic [3:0] ra3, input logic [3:0] ra4, input logic [3:0] wa3,
                         input logic [1:0] rw, input logic mtr, input logic pcs);
    hif.ValidD    = v;
    hif.RA1D      = ra1;
    hif.RA2D      = ra2;
    hif.RA3D      = ra3;
    hif.RA4D      = ra4;
    hif.WA3D      = wa3;
    hif.RegWriteD = rw;
    hif.MemtoRegD = mtr;
    hif.PCSrcD    = pcs;
  endtask

  function automatic logic [7:0] mvec();
    return {hif.Match_1E_M, hif.Match_1E_W, hif.Match_2E_M, hif.Match_2E_W,
            hif.Match_3E_M, hif.Match_3E_W, hif.Match_4E_M, hif.Match_4E_W};
  endfunction

  initial begin
    nt = 0;
    nf = 0;
    // Reset with busy D inputs and hazard strobes asserted.
    reset = 1'b1;
    drive_d(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 2'b11, 1'b1, 1'b0);
    hif.CondExE = 1'b1;
    hif.StallD  = 1'b1;
    hif.FlushE  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_match", {24'd0, mvec()}, 32'h0);
    chk("rst_m12d", {31'd0, hif.Match_12D_E}, 32'h0);
    chk("rst_rwm", {30'd0, hif.RegWriteM}, 32'h0);
    chk("rst_rww", {30'd0, hif.RegWriteW}, 32'h0);
    chk("rst_mtre", {31'd0, hif.MemtoRegE}, 32'h0);
    chk("rst_pcpend", {31'd0, hif.PCWrPendingF}, 32'h0);
    chk("rst_pcsw", {31'd0, hif.PCSrcW}, 32'h0);
    chk("rst_stall", {29'd0, hif.StallCnt}, 32'h0);
    chk("rst_flush", {29'd0, hif.FlushCnt}, 32'h0);
    hif.StallD = 1'b0;
    hif.FlushE = 1'b0;
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    tick();

    // Dependent pair: ADD r3 then a consumer of r3 (consumer presented twice).
    drive_d(1'b1, 4'd1, 4'd2, 4'd10, 4'd11, 4'd3, 2'b01, 1'b0, 1'b0);
    tick();
    drive_d(1'b1, 4'd3, 4'd7, 4'd8, 4'd9, 4'd4, 2'b01, 1'b0, 1'b0);
    #1;
    chk("dep_m12d_hit", {31'd0, hif.Match_12D_E}, 32'h1);
    chk("dep_match_e_only", {24'd0, mvec()}, 32'h0);
    tick();
    chk("dep_match_1em", {24'd0, mvec()}, 32'h80);
    chk("dep_rwm", {30'd0, hif.RegWriteM}, 32'h1);
    chk("dep_m12d_miss", {31'd0, hif.Match_12D_E}, 32'h0);
    tick();
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    #1;
    chk("dep_match_1ew", {24'd0, mvec()}, 32'h40);
    chk("dep_rww", {30'd0, hif.RegWriteW}, 32'h1);
    repeat (3) tick();
    chk("drain_match", {24'd0, mvec()}, 32'h0);

    // Load-use: LDR r5 in E, consumer of r5 in D, hazard unit stalls and flushes.
    drive_d(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 2'b01, 1'b1, 1'b0);
    tick();
    drive_d(1'b1, 4'd0, 4'd5, 4'd0, 4'd0, 4'd6, 2'b01, 1'b0, 1'b0);
    hif.StallD = 1'b1;
    hif.FlushE = 1'b1;
    #1;
    chk("ld_mtre", {31'd0, hif.MemtoRegE}, 32'h1);
    chk("ld_m12d", {31'd0, hif.Match_12D_E}, 32'h1);
    tick();
    hif.StallD = 1'b0;
    hif.FlushE = 1'b0;
    #1;
    chk("ld_bubble_mtre", {31'd0, hif.MemtoRegE}, 32'h0);
    chk("ld_bubble_m12d", {31'd0, hif.Match_12D_E}, 32'h0);
    chk("ld_rwm", {30'd0, hif.RegWriteM}, 32'h1);
    chk("ld_stall1", {29'd0, hif.StallCnt}, 32'h1);
    chk("ld_flush1", {29'd0, hif.FlushCnt}, 32'h1);
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    repeat (3) tick();

    // Condition fail with both write ports and a PC write in E.
    drive_d(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15, 2'b11, 1'b0, 1'b1);
    tick();
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    hif.CondExE = 1'b0;
    #1;
    chk("cf_pend_e", {31'd0, hif.PCWrPendingF}, 32'h1);
    tick();
    hif.CondExE = 1'b1;
    #1;
    chk("cf_rwm", {30'd0, hif.RegWriteM}, 32'h0);
    chk("cf_pend_gone", {31'd0, hif.PCWrPendingF}, 32'h0);
    tick();
    chk("cf_rww", {30'd0, hif.RegWriteW}, 32'h0);
    chk("cf_pcsw", {31'd0, hif.PCSrcW}, 32'h0);
    repeat (2) tick();

    // PC write travels D, E, M, then shows in W for one cycle.
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1);
    #1;
    chk("pc_invalid_d", {31'd0, hif.PCWrPendingF}, 32'h0);
    drive_d(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1);
    #1;
    chk("pc_pend_d", {31'd0, hif.PCWrPendingF}, 32'h1);
    tick();
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    #1;
    chk("pc_pend_e", {31'd0, hif.PCWrPendingF}, 32'h1);
    chk("pc_w_early", {31'd0, hif.PCSrcW}, 32'h0);
    tick();
    chk("pc_pend_m", {31'd0, hif.PCWrPendingF}, 32'h1);
    tick();
    chk("pc_pend_done", {31'd0, hif.PCWrPendingF}, 32'h0);
    chk("pc_srcw", {31'd0, hif.PCSrcW}, 32'h1);
    tick();
    chk("pc_srcw_drop", {31'd0, hif.PCSrcW}, 32'h0);

    // Saturation from 1: six stall cycles reach 7, four more hold it.
    hif.StallD = 1'b1;
    repeat (6) tick();
    chk("sat_reach", {29'd0, hif.StallCnt}, 32'h7);
    repeat (4) tick();
    chk("sat_hold", {29'd0, hif.StallCnt}, 32'h7);
    chk("sat_flush_unchanged", {29'd0, hif.FlushCnt}, 32'h1);
    hif.StallD = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("sat_rst_stall", {29'd0, hif.StallCnt}, 32'h0);
    chk("sat_rst_flush", {29'd0, hif.FlushCnt}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
